lstm_cell_update: RTL and testbench

Sequential LSTM cell-state/hidden-state update stage that consumes the four gate pre-activations produced by the gate multiply-add units (W*X + U*h + b, Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH signed fixed point). It applies hard-sigmoid/hard-tanh activations, updates the internal cell state c, and produces the new hidden state h. The fed-back h returns to the gate multiply-add units for the next timestep. Valid/ready handshake on both sides; one timestep in flight at a time.

---
 rtl/lstm_cell_update.sv | 153 +++++++++++++++
 tb/tb_lstm_cell_update.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lstm_cell_update.sv
// LSTM cell/hidden state update: hard-sigmoid/hard-tanh activations, c and h recurrence, valid/ready handshake.
// Build option: define LSTM_SAT_EN to saturate add()/mul() results instead of two's-complement wrap.
`timescale 1ns/1ps
module lstm_cell_update #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] pre_i,
    input  logic signed [DATA_WIDTH-1:0] pre_f,
    input  logic signed [DATA_WIDTH-1:0] pre_g,
    input  logic signed [DATA_WIDTH-1:0] pre_o,
    input  logic                         clear_state,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] h_out,
    output logic signed [DATA_WIDTH-1:0] c_out
);

    typedef enum logic [2:0] {S_IDLE, S_ACT, S_CELL, S_HID, S_DONE} state_t;

    localparam int ONE = 1 << FRACT_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] ACT_ONE     = DATA_WIDTH'(ONE);
    localparam logic signed [DATA_WIDTH-1:0] ACT_NEG_ONE = DATA_WIDTH'(-ONE);
    localparam logic signed [2*DATA_WIDTH-1:0] MUL_MAX =
        {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [2*DATA_WIDTH-1:0] MUL_MIN =
        {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t r_state, w_state_nxt;

    logic signed [DATA_WIDTH-1:0] r_pre_i, r_pre_f, r_pre_g, r_pre_o;
    logic signed [DATA_WIDTH-1:0] r_act_i, r_act_f, r_act_g, r_act_o;
    logic signed [DATA_WIDTH-1:0] r_c, r_h;

    function automatic logic signed [DATA_WIDTH-1:0] f_hsig(input logic signed [DATA_WIDTH-1:0] x);
        int v;
        v = (int'(x) >>> 2) + ONE / 2;
        if (v < 0)
            v = 0;
        else if (v > ONE)
            v = ONE;
        return DATA_WIDTH'(v);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] f_htanh(input logic signed [DATA_WIDTH-1:0] x);
        if (x > ACT_ONE)
            return ACT_ONE;
        else if (x < ACT_NEG_ONE)
            return ACT_NEG_ONE;
        else
            return x;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] f_mul(input logic signed [DATA_WIDTH-1:0] a,
                                                           input logic signed [DATA_WIDTH-1:0] b);
        logic signed [2*DATA_WIDTH-1:0] ax, bx, p;
        ax = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
        bx = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        p  = (ax * bx) >>> FRACT_WIDTH;
`ifdef LSTM_SAT_EN
        if (p > MUL_MAX)
            return D_MAX;
        else if (p < MUL_MIN)
            return D_MIN;
`endif
        return DATA_WIDTH'(p);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] f_add(input logic signed [DATA_WIDTH-1:0] a,
                                                           input logic signed [DATA_WIDTH-1:0] b);
        logic signed [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
`ifdef LSTM_SAT_EN
        // Overflow shows up as a disagreement between the guard bit and the result sign.
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
            return s[DATA_WIDTH] ? D_MIN : D_MAX;
`endif
        return DATA_WIDTH'(s);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_ACT;
            S_ACT:   w_state_nxt = S_CELL;
            S_CELL:  w_state_nxt = S_HID;
            S_HID:   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_i <= '0;
            r_pre_f <= '0;
            r_pre_g <= '0;
            r_pre_o <= '0;
            r_act_i <= '0;
            r_act_f <= '0;
            r_act_g <= '0;
            r_act_o <= '0;
            r_c     <= '0;
            r_h     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clear_state) begin
                        r_c <= '0;
                        r_h <= '0;
                    end
                    if (in_valid) begin
                        r_pre_i <= pre_i;
                        r_pre_f <= pre_f;
                        r_pre_g <= pre_g;
                        r_pre_o <= pre_o;
                    end
                end
                S_ACT: begin
                    r_act_i <= f_hsig(r_pre_i);
                    r_act_f <= f_hsig(r_pre_f);
                    r_act_o <= f_hsig(r_pre_o);
                    r_act_g <= f_htanh(r_pre_g);
                end
                S_CELL:  r_c <= f_add(f_mul(r_act_f, r_c), f_mul(r_act_i, r_act_g));
                S_HID:   r_h <= f_mul(r_act_o, f_htanh(r_c));
                default: ;
            endcase
        end
    end

    assign h_out = r_h;
    assign c_out = r_c;

endmodule

// File: tb/tb_lstm_cell_update.sv
// Directed, table-driven bench for lstm_cell_update (default 16-bit Q8.8), plus backpressure,
// saturation/wrap and mid-operation reset sequences. Expected values are hand-computed.
`timescale 1ns/1ps
module tb_lstm_cell_update;

    typedef struct packed {
        logic [15:0] pi;
        logic [15:0] pf;
        logic [15:0] pg;
        logic [15:0] po;
        logic        clr;
        logic [15:0] ec;
        logic [15:0] eh;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] pre_i = '0, pre_f = '0, pre_g = '0, pre_o = '0;
    logic        clear_state = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] h_out, c_out;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [8];

    lstm_cell_update #(.DATA_WIDTH(16), .FRACT_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pre_i      (pre_i),
        .pre_f      (pre_f),
        .pre_g      (pre_g),
        .pre_o      (pre_o),
        .clear_state(clear_state),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .h_out      (h_out),
        .c_out      (c_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({name, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd3);
    endtask

    task automatic run_step(input vec_t v, input string name);
        wait_ready(name);
        pre_i = v.pi; pre_f = v.pf; pre_g = v.pg; pre_o = v.po;
        clear_state = v.clr;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_state = 1'b0;
        wait_done(name);
        check({name, " c_out"}, 32'(c_out), 32'(v.ec));
        check({name, " h_out"}, 32'(h_out), 32'(v.eh));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " out_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        //          pre_i     pre_f     pre_g     pre_o     clr   c_exp     h_exp
        vecs[0] = '{16'h0400, 16'hFC00, 16'h0080, 16'h0400, 1'b1, 16'h0080, 16'h0080};
        vecs[1] = '{16'h0400, 16'h0400, 16'h0100, 16'h0400, 1'b1, 16'h0100, 16'h0100};
        vecs[2] = '{16'h0400, 16'h0400, 16'h0100, 16'h0400, 1'b0, 16'h0200, 16'h0100};
        vecs[3] = '{16'h0400, 16'h0400, 16'h0100, 16'h0400, 1'b0, 16'h0300, 16'h0100};
        vecs[4] = '{16'h0400, 16'h0000, 16'hFE00, 16'h0000, 1'b0, 16'h0080, 16'h0040};
        vecs[5] = '{16'h0100, 16'hFF00, 16'hFF80, 16'h0200, 1'b0, 16'hFFC0, 16'hFFC0};
        vecs[6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 16'hFFDF, 16'hFFEF};
        vecs[7] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b1, 16'h0100, 16'h0000};

        // Reset values
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset c_out", 32'(c_out), 32'd0);
        check("reset h_out", 32'(h_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_step(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: result held in DONE while a competing bundle waits upstream
        wait_ready("bp");
        pre_i = 16'h0400; pre_f = 16'h0400; pre_g = 16'h0100; pre_o = 16'h0400;
        clear_state = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        pre_i = 16'h8000; pre_f = 16'h8000; pre_g = 16'h8000; pre_o = 16'h8000;
        clear_state = 1'b1;
        wait_done("bp");
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d c_out", k), 32'(c_out), 32'h0200);
            check($sformatf("bp%0d h_out", k), 32'(h_out), 32'h0100);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        clear_state = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp consume out_valid", 32'(out_valid), 32'd0);
        check("bp consume in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("bp no_capture out_valid", 32'(out_valid), 32'd0);
        check("bp no_capture c_out", 32'(c_out), 32'h0200);
        check("bp no_capture h_out", 32'(h_out), 32'h0100);

        // Saturation: accumulate 1.0 per step to 127.0, then one more
        v = '{16'h0400, 16'h0400, 16'h0100, 16'h0400, 1'b1, 16'h0100, 16'h0100};
        run_step(v, "sat_start");
        for (int k = 2; k <= 127; k++) begin
            v.clr = 1'b0;
            v.ec  = 16'(k * 256);
            run_step(v, $sformatf("sat_acc%0d", k));
        end
`ifdef LSTM_SAT_EN
        v.ec = 16'h7FFF;
        v.eh = 16'h0100;
`else
        v.ec = 16'h8000;
        v.eh = 16'hFF00;
`endif
        run_step(v, "sat_edge");

        // Mid-operation reset during CELL
        wait_ready("mid");
        pre_i = 16'h0400; pre_f = 16'h0400; pre_g = 16'h0100; pre_o = 16'h0400;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst out_valid", 32'(out_valid), 32'd0);
        check("mid_rst in_ready", 32'(in_ready), 32'd1);
        check("mid_rst c_out", 32'(c_out), 32'd0);
        check("mid_rst h_out", 32'(h_out), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000};
        run_step(v, "post_rst");
        check("post_rst act_i", 32'(dut.r_act_i), 32'h0080);
        check("post_rst act_f", 32'(dut.r_act_f), 32'h0080);
        check("post_rst act_o", 32'(dut.r_act_o), 32'h0080);
        check("post_rst act_g", 32'(dut.r_act_g), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
